seq_mul_ctrl: RTL and testbench



---
 rtl/seq_mul_ctrl_pkg.sv | 32 +++
 rtl/seq_mul_ctrl_adder.sv | 25 ++
 rtl/seq_mul_ctrl.sv | 100 ++++++++++
 tb/tb_seq_mul_ctrl.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/seq_mul_ctrl_pkg.sv
// Shared definitions for the sequenced arithmetic blocks: state encodings,
// datapath widths and a carry-chain incrementer for iteration counters.
package seq_mul_ctrl_pkg;

  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned PROD_W    = 2 * DEF_WIDTH;
  localparam int unsigned ADDER_W   = 16;
  localparam int unsigned CNT_W     = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  function automatic int unsigned prod_width(input int unsigned width);
    return 2 * width;
  endfunction

  // Half-adder chain so counters never need a behavioural adder.
  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] r;
    logic             c;
    c = 1'b1;
    for (int i = 0; i < CNT_W; i++) begin
      r[i] = v[i] ^ c;
      c    = c & v[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/seq_mul_ctrl_adder.sv
// 16-bit ripple-carry add/sub cell: x_i=1 inverts b_i (caller supplies cin_i=1
// to complete a two's-complement subtract).
module Sixteen_b_full_adder (
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  input  logic        x_i,
  input  logic        cin_i,
  output logic [15:0] sum_o,
  output logic        cout_o
);

  logic [15:0] b_eff;
  logic [16:0] carry;

  assign carry[0] = cin_i;

  for (genvar i = 0; i < 16; i++) begin : g_bit
    assign b_eff[i]    = b_i[i] ^ x_i;
    assign sum_o[i]    = a_i[i] ^ b_eff[i] ^ carry[i];
    assign carry[i+1]  = (a_i[i] & b_eff[i]) | (carry[i] & (a_i[i] ^ b_eff[i]));
  end

  assign cout_o = carry[16];

endmodule

// File: rtl/seq_mul_ctrl.sv
// Shift-and-add unsigned multiplier controller: one partial product per clock
// through a shared 16-bit ripple adder, with a start/busy/done handshake.
module seq_mul_ctrl
  import seq_mul_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         abort,
  input  logic [WIDTH-1:0]             a,
  input  logic [WIDTH-1:0]             b,
  output logic                         busy,
  output logic                         done,
  output logic [prod_width(WIDTH)-1:0] product
);

  localparam int unsigned PW = prod_width(WIDTH);

  state_e             state_q;
  logic [ADDER_W-1:0] mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [ADDER_W-1:0] acc_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               busy_q;
  logic               done_q;
  logic [PW-1:0]      product_q;

  logic [ADDER_W-1:0] adder_sum;
  logic               adder_cout_unused;

  // Carry-out is always 0 here: the accumulator never exceeds 2*WIDTH <= 16 bits.
  Sixteen_b_full_adder u_adder (
    .a_i    (acc_q),
    .b_i    (mcand_q),
    .x_i    (1'b0),
    .cin_i  (1'b0),
    .sum_o  (adder_sum),
    .cout_o (adder_cout_unused)
  );

  // NOTE: all state lives in one clocked block and is written with <= so every
  // register sees the pre-edge values of the others, regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          busy_q <= start;
          if (start) begin
            mcand_q  <= ADDER_W'(a);
            mplier_q <= b;
            acc_q    <= '0;
            cnt_q    <= '0;
            state_q  <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (abort) begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            if (mplier_q[0]) acc_q <= adder_sum;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_inc(cnt_q);
            if (cnt_q == CNT_W'(WIDTH - 1)) state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          // busy stays high through the done-pulse cycle so a held start is
          // accepted back-to-back without a busy gap.
          product_q <= acc_q[PW-1:0];
          done_q    <= 1'b1;
          busy_q    <= 1'b1;
          state_q   <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;

endmodule

// File: tb/tb_seq_mul_ctrl.sv
// Self-checking bench for seq_mul_ctrl: directed handshake scenarios plus
// random operand jobs compared against an arithmetic product model.
module tb_seq_mul_ctrl;

  localparam int unsigned W = 8;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          abort;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          busy;
  logic          done;
  logic [2*W-1:0] product;

  int checks   = 0;
  int failures = 0;

  seq_mul_ctrl #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .abort   (abort),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] model_mul(input int unsigned x, input int unsigned y);
    return 16'(x * y);
  endfunction

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic wait_edge();
    @(posedge clk);
    #1;
  endtask

  // Issue one job, then follow it to its done pulse, checking latency,
  // busy duration, the product and the return to idle.
  task automatic run_job(input logic [W-1:0] ja, input logic [W-1:0] jb,
                         input bit abort_too, input string tag);
    int          edges;
    int          busy_n;
    bit          seen;
    logic [15:0] exp_p;
    exp_p  = model_mul(ja, jb);
    a      = ja;
    b      = jb;
    start  = 1'b1;
    abort  = abort_too;
    wait_edge();
    start  = 1'b0;
    abort  = 1'b0;
    a      = W'($urandom);
    b      = W'($urandom);
    edges  = 0;
    busy_n = 0;
    seen   = 1'b0;
    while (!seen && edges < 20) begin
      if (busy) busy_n++;
      wait_edge();
      edges++;
      seen = done;
    end
    if (busy) busy_n++;
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    check({tag, "_latency"}, 32'(edges), 32'd9);
    check({tag, "_busy_cycles"}, 32'(busy_n), 32'd10);
    check({tag, "_product"}, 32'(product), 32'(exp_p));
    wait_edge();
    check({tag, "_idle_busy"}, 32'(busy), 32'd0);
    check({tag, "_idle_done"}, 32'(done), 32'd0);
  endtask

  initial begin
    int          done_cnt;
    int          done_at [$];
    int          busy_low;
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    a     = '0;
    b     = '0;

    // Reset state
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_product", 32'(product), 32'd0);
    #1 rst_n = 1'b1;
    wait_edge();
    check("idle_busy", 32'(busy), 32'd0);

    // Basic job and boundary operands
    run_job(8'd13, 8'd11, 1'b0, "t1_13x11");
    run_job(8'd255, 8'd255, 1'b0, "t2_max");
    run_job(8'd0, 8'd200, 1'b0, "t2_zero_a");
    run_job(8'd77, 8'd0, 1'b0, "t2_zero_b");

    // start and abort together in IDLE: start wins
    run_job(8'd21, 8'd3, 1'b1, "start_over_abort");

    // abort in IDLE is ignored
    abort = 1'b1;
    wait_edge();
    abort = 1'b0;
    check("idle_abort_busy", 32'(busy), 32'd0);
    check("idle_abort_product", 32'(product), 32'(model_mul(21, 3)));

    // start during RUN is ignored; exactly one done pulse
    a = 8'd3; b = 8'd5; start = 1'b1;
    wait_edge();
    start = 1'b0;
    repeat (3) wait_edge();
    a = 8'd7; b = 8'd7; start = 1'b1;
    wait_edge();
    start = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 15; i++) begin
      wait_edge();
      if (done) done_cnt++;
    end
    check("t3_done_count", 32'(done_cnt), 32'd1);
    check("t3_product", 32'(product), 32'h000F);
    check("t3_idle", 32'(busy), 32'd0);

    // abort mid-RUN: no done, product unchanged
    a = 8'd9; b = 8'd9; start = 1'b1;
    wait_edge();
    start = 1'b0;
    repeat (3) wait_edge();
    abort = 1'b1;
    wait_edge();
    abort = 1'b0;
    check("t4_busy_drop", 32'(busy), 32'd0);
    done_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      wait_edge();
      if (done) done_cnt++;
    end
    check("t4_no_done", 32'(done_cnt), 32'd0);
    check("t4_product_kept", 32'(product), 32'h000F);
    run_job(8'd2, 8'd2, 1'b0, "t4_after_abort");

    // Asynchronous reset mid-RUN
    a = 8'd200; b = 8'd100; start = 1'b1;
    wait_edge();
    start = 1'b0;
    repeat (4) wait_edge();
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_busy", 32'(busy), 32'd0);
    check("t5_rst_done", 32'(done), 32'd0);
    check("t5_rst_product", 32'(product), 32'd0);
    #3 rst_n = 1'b1;
    wait_edge();
    check("t5_post_rst_idle", 32'(busy), 32'd0);
    run_job(8'd6, 8'd7, 1'b0, "t5_6x7");

    // start held high: back-to-back jobs every 10 cycles
    a = 8'd1; b = 8'd1; start = 1'b1;
    wait_edge();
    busy_low = 0;
    for (int e = 1; e <= 29; e++) begin
      wait_edge();
      if (!busy) busy_low++;
      if (done) begin
        done_at.push_back(e);
        check("t6_product", 32'(product), 32'h0001);
      end
      if (e == 29) start = 1'b0;
    end
    check("t6_done_count", 32'(done_at.size()), 32'd3);
    check("t6_busy_gap", 32'(busy_low), 32'd0);
    if (done_at.size() == 3) begin
      check("t6_first_done", 32'(done_at[0]), 32'd9);
      check("t6_period_1", 32'(done_at[1] - done_at[0]), 32'd10);
      check("t6_period_2", 32'(done_at[2] - done_at[1]), 32'd10);
    end
    wait_edge();
    check("t6_idle", 32'(busy), 32'd0);

    // Random operands against the arithmetic model
    for (int j = 0; j < 8; j++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      run_job(ra, rb, 1'b0, "rand_job");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
